csa_resolver: RTL
=================

Name: csa_resolver

Overview:
- Final-stage consumer for the 4:2 compressor tree: takes one redundant (sum vector, carry vector) pair and resolves it into a binary result with a carry-propagate add.
- Multi-cycle, CHUNK bits per cycle, so a narrow adder serves wide partial-product rows.
- Valid/ready on input (from tree output register) and output (to product register / error-metric logic).

Parameters:
- W, 32, width of sv, cv and p; must be an integer multiple of CHUNK
- CHUNK, 8, bits resolved per ADD cycle; N = W/CHUNK chunk cycles (N >= 1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sv/cv valid
- in_ready  output  1  block can accept a pair this cycle
- sv  input  W  sum vector; bit i has weight 2^i
- cv  input  W  carry vector, pre-aligned by producer; bit i has weight 2^i
- out_valid  output  1  p/ovf hold a resolved result
- out_ready  input  1  downstream accepts result
- p  output  W  (sv + cv) mod 2^W
- ovf  output  1  carry out of bit W-1
- busy  output  1  high in ADD state

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1 after release; out_valid=0; p=0; ovf=0; busy=0; internal sv/cv/acc registers, chunk index and carry cleared. Takes effect immediately, including mid-ADD or in DONE; the in-flight pair and any unconsumed result are discarded.
- States: IDLE, ADD, DONE.
- in_ready = (state==IDLE) or (state==DONE and out_ready). Combinational; the only comb path is out_ready -> in_ready.
- Accept: in_valid and in_ready high at a rising edge. sv/cv are registered, idx=0, carry=0, state->ADD. Accept from IDLE, or from DONE concurrent with result handoff, is a back-to-back transfer.
- ADD, one edge per chunk: {c, s} = sv_r[idx*CHUNK +: CHUNK] + cv_r[same] + carry. s goes to acc chunk idx; carry=c; idx++. in_valid is ignored in ADD.
- After the edge that processes chunk N-1: p<=acc with the final chunk merged; ovf<=final carry; out_valid<=1; state->DONE.
- Latency: accept at edge k -> out_valid high after edge k+N. W=32, CHUNK=8 gives 4 cycles. CHUNK=W gives 1 cycle.
- DONE: p, ovf and out_valid held stable while out_ready=0, with no limit on stall length.
  - out_ready=1 and in_valid=0: out_valid->0, state->IDLE.
  - out_ready=1 and in_valid=1: new pair accepted and state->ADD in the same edge; out_valid->0.
- p and ovf change only on entry to DONE or on reset. They keep the last result after handoff; consumers qualify them with out_valid.
- Throughput: one result per N+1 cycles with out_ready tied high and continuous in_valid.
- Arithmetic is unsigned modulo 2^W; the full sum is {ovf, p}. No sign handling; signed interpretation is the consumer's job.
- X on sv/cv when not accepted must not propagate into state.

Test Plan:
- W=32, CHUNK=8, sv=0x0000FFFF, cv=0x00000001, out_ready=1 -> out_valid exactly 4 edges after accept; p=0x00010000, ovf=0; busy high for those 4 cycles.
- sv=0xFFFFFFFF, cv=0x00000001 -> p=0x00000000, ovf=1. Checks the carry chain through all chunk boundaries.
- Backpressure: result p=0x12345678 with out_ready=0 for 6 cycles -> p, ovf and out_valid stable; in_ready=0; a new in_valid pulse is not accepted until the cycle out_ready=1.
- Back-to-back: in_valid and out_ready held high, pairs (1,2), (0x80000000,0x80000000), (0xAAAAAAAA,0x55555555) -> results 3/ovf0, 0/ovf1, 0xFFFFFFFF/ovf0. One result per 5 cycles; accept coincides with handoff in DONE.
- Reset mid-operation: rst_n low during the 2nd ADD cycle -> out_valid=0, p=0, ovf=0 immediately. After release the state is IDLE with in_ready=1, and the next pair (5,7) gives p=12.
- Random: 2000 random (sv, cv) pairs with random out_ready stalls, at both CHUNK=8 and CHUNK=32 -> {ovf, p} equals the 33-bit sum sv+cv. No result dropped or duplicated.

Source files
------------

// File: rtl/csa_resolver.sv
// Carry-propagate resolver for a redundant (sum, carry) vector pair.
// Adds CHUNK bits per cycle over N = W/CHUNK cycles, with valid/ready on both sides.
module csa_resolver #(
    parameter int unsigned W     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] sv,
    input  logic [W-1:0] cv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] p,
    output logic         ovf,
    output logic         busy
);

    localparam int unsigned N    = W / CHUNK;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    sv_q, cv_q, acc_q, p_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q, ovf_q, out_valid_q;

    logic [31:0]     base;
    logic [CHUNK:0]  chunk_sum;
    logic [W-1:0]    acc_d;
    logic            accept;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q == ADD);

    // acc_d carries the current chunk merged in, so the final edge can publish it directly
    always_comb begin
        base      = 32'(idx_q) * CHUNK;
        chunk_sum = {1'b0, sv_q[base +: CHUNK]} + {1'b0, cv_q[base +: CHUNK]}
                  + (CHUNK + 1)'(carry_q);
        acc_d     = acc_q;
        acc_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sv_q        <= '0;
            cv_q        <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sv_q    <= sv;
                        cv_q    <= cv;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        carry_q <= 1'b0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    acc_q   <= acc_d;
                    carry_q <= chunk_sum[CHUNK];
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        p_q         <= acc_d;
                        ovf_q       <= chunk_sum[CHUNK];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            sv_q    <= sv;
                            cv_q    <= cv;
                            acc_q   <= '0;
                            idx_q   <= '0;
                            carry_q <= 1'b0;
                            state_q <= ADD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
